permutation_engine: RTL and testbench
=====================================

Name: permutation_engine

Overview:
- Iterative ASCON permutation core: one full round (constant addition → substitution → linear diffusion) per clock on a registered 320-bit state.
- Supports p^a (12 rounds) and p^b (6 rounds) under a start/done handshake.
- Placement: directly upstream of the 64-column substitution_layer (supplies the constant-added state), and consumes its output via the diffusion stage.
- Slots below the mode/XOR-injection FSM of the ASCON-128 top.

Parameters:
- NB_ROUNDS_A, 12, round count for p^a.
- NB_ROUNDS_B, 6, round count for p^b; must be ≤ NB_ROUNDS_A.

Ports:
- clock_i  in  1  system clock; all state updates on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  request a permutation; sampled only in IDLE or DONE.
- round_sel_i  in  1  0 = p^a (12 rounds), 1 = p^b (6 rounds); sampled with start_i.
- state_i  in  type_state (5x64)  input state; x0 = state_i[0] … x4 = state_i[4]; sampled with start_i.
- state_o  out  type_state  registered state; valid while done_o = 1 and held until the next accepted start.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse in DONE.

Behaviour:
- Reset (reset_i = 1 at an edge), including mid-RUN:
  - state register = 0, round counter = 0, FSM = IDLE.
  - busy_o = 0, done_o = 0; any run in progress is aborted with no done_o.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE with start_i = 1:
    - load state_i.
    - round counter ← 0 if round_sel_i = 0, else NB_ROUNDS_A − NB_ROUNDS_B (= 6).
    - go to RUN.
  - IDLE with start_i = 0: hold.
  - RUN: every edge, state ← L(S(C(state, cnt))) and cnt ← cnt + 1. The edge that applies round cnt = 11 moves to DONE.
  - DONE: lasts one cycle, then IDLE unless start_i = 1, which restarts immediately (back-to-back).
- start_i in RUN is ignored, with no queuing.
- round_sel_i and state_i are don't-care except at the accepting edge.
- Latency: start sampled at edge E0 → done_o high during the cycle after edge E0+12 (p^a) or E0+6 (p^b). Throughput is 1 permutation per 13/7 cycles.
- Constant addition:
  - x2[7:0] ^= {4'hF − cnt[3:0], cnt[3:0]}; all other bits unchanged.
  - Sequence: 0xF0, 0xE1, 0xD2, 0xC3, 0xB4, 0xA5, 0x96, 0x87, 0x78, 0x69, 0x5A, 0x4B.
  - p^b uses the last six only.
- Substitution: the existing substitution_layer instance. Column i = {x0[i], x1[i], x2[i], x3[i], x4[i]}, MSB = x0.
- Linear diffusion, using right rotations (ror) on 64-bit words:
  - x0 ^= ror19 ^ ror28
  - x1 ^= ror61 ^ ror39
  - x2 ^= ror1 ^ ror6
  - x3 ^= ror10 ^ ror17
  - x4 ^= ror7 ^ ror41
- Round counter: 4 bits, never exceeds 11 in RUN, no wrap. Values 12–15 are unreachable; if reached, the FSM goes to IDLE.
- busy_o and done_o are decoded from the FSM register, so they are glitch-free.
- busy_o and done_o are never high together.

Decomposition:
- ascon_pack holds:
  - type_state (existing).
  - Round-count constants.
  - Round-constant function or 12-entry array.
  - Rotation amounts.
  - FSM state enum.
- Sub-modules:
  - constant_addition (combinational, x2 byte XOR), feeding substitution_layer.
  - diffusion_layer (combinational), consuming substitution_layer output.
- permutation_engine holds only the registers, counter and FSM, instantiating the three layers in series.

Test Plan:
- Reset then idle: reset_i = 1 for 2 cycles, start_i = 0 → state_o = 0, busy_o = 0, done_o = 0 for 20 cycles.
- p^a on the ASCON-128 initial state (x0 = 0x80400C0600000000, key = 0, nonce = 0), start one cycle →
  - busy_o = 1 for exactly 12 cycles, then done_o = 1 for exactly 1 cycle.
  - state_o equals the golden model (C reference permutation).
  - Bench probe on the internal constant shows 0xF0…0x4B in order.
- p^b on an all-zero state, round_sel_i = 1 →
  - done_o 7 cycles after the accepting edge.
  - Constant probe sequence 0x96, 0x87, 0x78, 0x69, 0x5A, 0x4B.
  - state_o matches the golden model.
- start_i held high with state_i changing every cycle during RUN →
  - Result depends only on the state_i present at the accepting edge.
  - A new run begins exactly in the DONE cycle (back-to-back): 13-cycle period for p^a.
- reset_i asserted at round 5 of p^a →
  - Next cycle: IDLE, state_o = 0, no done_o.
  - A following start completes normally with correct output.
- Random regression: 1000 random states, random round_sel_i, random start gaps → every state_o at done_o matches the golden model; no done_o without a prior accepted start.

Source files
------------

// File: rtl/ascon_pack.sv
`default_nettype none
// ============================================================================
// Module      : ascon_pack
// Description : Shared types, round constants, S-box and rotation amounts
//               for the ASCON permutation datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package ascon_pack;

    // x0 = state[0] ... x4 = state[4], each a 64-bit word
    typedef logic [4:0][63:0] type_state;

    localparam int c_nb_rounds_a = 12;
    localparam int c_nb_rounds_b = 6;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Per-word right-rotation pairs of the linear diffusion layer
    localparam int unsigned c_rot_a [5] = '{19, 61, 1, 10, 7};
    localparam int unsigned c_rot_b [5] = '{28, 39, 6, 17, 41};

    // 5-bit S-box indexed by column {x0,x1,x2,x3,x4}, x0 as MSB
    localparam logic [4:0] c_sbox [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [7:0] round_constant(input logic [3:0] cnt);
        return {4'hF - cnt, cnt};
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/constant_addition.sv
`default_nettype none
// ============================================================================
// Module      : constant_addition
// Description : XORs the round constant into the low byte of x2.
// Revision    : 1.0 - initial release
// ============================================================================
module constant_addition
    import ascon_pack::*;
(
    input  type_state  i_state,
    input  logic [7:0] i_const,
    output type_state  o_state
);

    always_comb begin
        o_state          = i_state;
        o_state[2][7:0]  = i_state[2][7:0] ^ i_const;
    end

endmodule
`default_nettype wire

// File: rtl/diffusion_layer.sv
`default_nettype none
// ============================================================================
// Module      : diffusion_layer
// Description : Per-word linear mixing x ^= ror(x,a) ^ ror(x,b).
// Revision    : 1.0 - initial release
// ============================================================================
module diffusion_layer
    import ascon_pack::*;
(
    input  type_state i_state,
    output type_state o_state
);

    for (genvar w = 0; w < 5; w++) begin : g_word
        assign o_state[w] = i_state[w]
                          ^ ror64(i_state[w], c_rot_a[w])
                          ^ ror64(i_state[w], c_rot_b[w]);
    end

endmodule
`default_nettype wire

// File: rtl/substitution_layer.sv
`default_nettype none
// ============================================================================
// Module      : substitution_layer
// Description : 64 parallel 5-bit S-boxes, one per bit column of the state.
// Revision    : 1.0 - initial release
// ============================================================================
module substitution_layer
    import ascon_pack::*;
(
    input  type_state i_state,
    output type_state o_state
);

    logic [4:0] w_col;

    always_comb begin
        o_state = '0;
        w_col   = '0;
        for (int i = 0; i < 64; i++) begin
            w_col = c_sbox[{i_state[0][i], i_state[1][i], i_state[2][i],
                            i_state[3][i], i_state[4][i]}];
            o_state[0][i] = w_col[4];
            o_state[1][i] = w_col[3];
            o_state[2][i] = w_col[2];
            o_state[3][i] = w_col[1];
            o_state[4][i] = w_col[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/permutation_engine.sv
`default_nettype none
// ============================================================================
// Module      : permutation_engine
// Description : Iterative ASCON p^a / p^b core, one round per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module permutation_engine
    import ascon_pack::*;
#(
    parameter int NB_ROUNDS_A = c_nb_rounds_a,
    parameter int NB_ROUNDS_B = c_nb_rounds_b
) (
    input  logic      clock_i,
    input  logic      reset_i,
    input  logic      start_i,
    input  logic      round_sel_i,
    input  type_state state_i,
    output type_state state_o,
    output logic      busy_o,
    output logic      done_o
);

    localparam logic [3:0] c_cnt_last = 4'(NB_ROUNDS_A - 1);
    // p^b runs the tail of the p^a constant schedule
    localparam logic [3:0] c_cnt_pb   = 4'(NB_ROUNDS_A - NB_ROUNDS_B);

    type_state  r_state;
    logic [3:0] r_round;
    logic [1:0] r_fsm;

    type_state  w_added;
    type_state  w_subbed;
    type_state  w_next;
    logic [7:0] w_round_const;

    assign w_round_const = round_constant(r_round);

    constant_addition u_constant_addition (
        .i_state (r_state),
        .i_const (w_round_const),
        .o_state (w_added)
    );

    substitution_layer u_substitution_layer (
        .i_state (w_added),
        .o_state (w_subbed)
    );

    diffusion_layer u_diffusion_layer (
        .i_state (w_subbed),
        .o_state (w_next)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= '0;
            r_round <= '0;
            r_fsm   <= c_st_idle;
        end else begin
            case (r_fsm)
                c_st_idle, c_st_done: begin
                    if (start_i) begin
                        r_state <= state_i;
                        r_round <= round_sel_i ? c_cnt_pb : 4'd0;
                        r_fsm   <= c_st_run;
                    end else begin
                        r_fsm   <= c_st_idle;
                    end
                end
                c_st_run: begin
                    if (r_round > c_cnt_last) begin
                        r_fsm <= c_st_idle;
                    end else begin
                        r_state <= w_next;
                        if (r_round == c_cnt_last) begin
                            r_fsm <= c_st_done;
                        end else begin
                            r_round <= r_round + 4'd1;
                        end
                    end
                end
                default: r_fsm <= c_st_idle;
            endcase
        end
    end

    assign state_o = r_state;
    assign busy_o  = (r_fsm == c_st_run);
    assign done_o  = (r_fsm == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_permutation_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_permutation_engine
// Description : Directed and random self-checking bench for permutation_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_permutation_engine;
    import ascon_pack::*;

    logic      clock_i = 1'b0;
    logic      reset_i;
    logic      start_i;
    logic      round_sel_i;
    type_state state_i;
    type_state state_o;
    logic      busy_o;
    logic      done_o;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [7:0] c_rc_tab [12] = '{
        8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
    };

    permutation_engine dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .round_sel_i (round_sel_i),
        .state_i     (state_i),
        .state_o     (state_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [319:0] act, input logic [319:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Bit-sliced reference permutation, written from the C implementation
    function automatic type_state model_perm(input type_state s, input int nr);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        type_state r;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        for (int k = 12 - nr; k < 12; k++) begin
            x2 ^= {56'd0, c_rc_tab[k]};
            x0 ^= x4; x4 ^= x3; x2 ^= x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3;
            t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
            x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
            x0 ^= rotr(x0, 19) ^ rotr(x0, 28);
            x1 ^= rotr(x1, 61) ^ rotr(x1, 39);
            x2 ^= rotr(x2, 1)  ^ rotr(x2, 6);
            x3 ^= rotr(x3, 10) ^ rotr(x3, 17);
            x4 ^= rotr(x4, 7)  ^ rotr(x4, 41);
        end
        r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3; r[4] = x4;
        return r;
    endfunction

    function automatic type_state rand_state();
        type_state r;
        for (int w = 0; w < 5; w++) r[w] = {$urandom(), $urandom()};
        return r;
    endfunction

    // Call from IDLE; returns in IDLE one cycle after the done pulse
    task automatic run_perm(input type_state s, input logic sel, input string tag);
        int nr;
        int cyc;
        type_state exp;
        nr  = sel ? 6 : 12;
        exp = model_perm(s, nr);
        start_i     = 1'b1;
        state_i     = s;
        round_sel_i = sel;
        tick();
        start_i     = 1'b0;
        state_i     = rand_state();
        round_sel_i = ~sel;
        cyc = 0;
        while (busy_o && cyc < 20) begin
            if (cyc < nr)
                check({tag, " rc"}, 320'(dut.w_round_const), 320'(c_rc_tab[12 - nr + cyc]));
            cyc++;
            tick();
        end
        check({tag, " busy_cycles"}, 320'(cyc), 320'(nr));
        check({tag, " done"}, 320'({busy_o, done_o}), 320'(2'b01));
        check({tag, " state"}, 320'(state_o), 320'(exp));
        tick();
        check({tag, " done_pulse"}, 320'({busy_o, done_o}), 320'(2'b00));
        check({tag, " state_hold"}, 320'(state_o), 320'(exp));
    endtask

    initial begin
        type_state s;
        type_state exp;
        type_state nxt;
        int n_done;
        int last_done;

        reset_i     = 1'b1;
        start_i     = 1'b0;
        round_sel_i = 1'b0;
        state_i     = '0;
        tick();
        tick();
        reset_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            check("idle state", 320'(state_o), 320'd0);
            check("idle flags", 320'({busy_o, done_o}), 320'(2'b00));
            tick();
        end

        // ASCON-128 initialisation state, zero key and nonce
        s    = '0;
        s[0] = 64'h80400C0600000000;
        run_perm(s, 1'b0, "pa_init");

        run_perm('0, 1'b1, "pb_zero");

        // Back-to-back runs with start_i held high and state_i churning
        s           = rand_state();
        exp         = model_perm(s, 12);
        start_i     = 1'b1;
        round_sel_i = 1'b0;
        state_i     = s;
        tick();
        n_done    = 0;
        last_done = -1;
        for (int c = 0; c < 60; c++) begin
            if (done_o) begin
                n_done++;
                check("b2b state", 320'(state_o), 320'(exp));
                if (last_done >= 0) check("b2b period", 320'(c - last_done), 320'd13);
                last_done = c;
                if (n_done == 3) begin
                    start_i = 1'b0;
                    break;
                end
                nxt     = rand_state();
                state_i = nxt;
                exp     = model_perm(nxt, 12);
            end else begin
                state_i = rand_state();
            end
            tick();
        end
        check("b2b done_count", 320'(n_done), 320'd3);
        tick();
        check("b2b idle", 320'({busy_o, done_o}), 320'(2'b00));

        // Reset while round 5 of p^a is pending
        start_i     = 1'b1;
        round_sel_i = 1'b0;
        state_i     = rand_state();
        tick();
        start_i = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        check("abort busy_before", 320'(busy_o), 320'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("abort state", 320'(state_o), 320'd0);
        check("abort flags", 320'({busy_o, done_o}), 320'(2'b00));
        for (int c = 0; c < 10; c++) begin
            check("abort no_done", 320'(done_o), 320'd0);
            tick();
        end
        run_perm(rand_state(), 1'b0, "after_abort");

        for (int i = 0; i < 1000; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                check("rand gap_done", 320'(done_o), 320'd0);
                tick();
            end
            run_perm(rand_state(), 1'($urandom_range(0, 1)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
